// File: rtl/serial_pkg.sv
// serial_pkg: shared framing constants and receiver state type for the serial column link.
package serial_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    localparam logic FRAME_START = 1'b1;
    localparam logic FRAME_STOP = 1'b0;
    localparam int DEF_DATA_BITS = 3;
    localparam int DEF_MAX_INDEX = 6;
    localparam int DEF_ERR_W = 8;
endpackage

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial input and decoded column/status outputs of the frame receiver.
interface serial_frame_rx_if #(
    parameter int DATA_BITS = 3,
    parameter int ERR_W = 8
) ();
    logic                 bit_in;
    logic [DATA_BITS-1:0] col_index;
    logic                 col_toggle;
    logic                 frame_ok;
    logic                 parity_err;
    logic                 frame_err;
    logic                 range_err;
    logic [ERR_W-1:0]     err_count;
    logic                 busy;
    modport master (
        input  bit_in,
        output col_index, col_toggle, frame_ok, parity_err, frame_err, range_err, err_count, busy
    );
    modport slave (
        output bit_in,
        input  col_index, col_toggle, frame_ok, parity_err, frame_err, range_err, err_count, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/parity/stop framed receiver yielding a validated column index and toggle handshake.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int PARITY_ODD = 1,
    parameter int MAX_INDEX = DEF_MAX_INDEX,
    parameter int ERR_W = DEF_ERR_W
) (
    input logic clk_in,
    input logic reset,
    serial_frame_rx_if.master bus
);
    localparam int CW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    rx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0]        bit_cnt;
    logic                 par_bit;
    logic                 par_ok;
    assign par_ok = (^{shreg, par_bit}) == PARITY_ODD[0];
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            bus.col_index <= '0;
            bus.col_toggle <= 1'b0;
            bus.frame_ok <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.range_err <= 1'b0;
            bus.err_count <= '0;
            bus.busy <= 1'b0;
        end else begin
            bus.frame_ok <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.range_err <= 1'b0;
            bus.busy <= state == IDLE ? bus.bit_in == FRAME_START : state != STOP;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (bus.bit_in == FRAME_START) state <= DATA;
                end
                DATA: begin
                    shreg[bit_cnt] <= bus.bit_in;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DATA_BITS - 1)) state <= PARITY;
                end
                PARITY: begin
                    par_bit <= bus.bit_in;
                    state <= STOP;
                end
                STOP: begin
                    // Stop edge always returns to IDLE, so a stop of 1 never starts a frame
                    state <= IDLE;
                    if (bus.bit_in != FRAME_STOP) bus.frame_err <= 1'b1;
                    else if (!par_ok) bus.parity_err <= 1'b1;
                    else if (int'(shreg) > MAX_INDEX) bus.range_err <= 1'b1;
                    else begin
                        bus.col_index <= shreg;
                        bus.col_toggle <= ~bus.col_toggle;
                        bus.frame_ok <= 1'b1;
                    end
                    if ((bus.bit_in != FRAME_STOP || !par_ok || int'(shreg) > MAX_INDEX) && bus.err_count != '1)
                        bus.err_count <= bus.err_count + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frame sequences with hand-computed expectations checked by immediate assertions.
module tb_serial_frame_rx;
    logic clk_in = 1'b0;
    logic reset = 1'b1;
    int passes = 0;
    int total = 0;
    serial_frame_rx_if #(.DATA_BITS(3), .ERR_W(8)) bus ();
    serial_frame_rx dut (.clk_in(clk_in), .reset(reset), .bus(bus));
    always #5 clk_in = ~clk_in;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask
    task automatic step(input logic b);
        @(negedge clk_in);
        bus.bit_in = b;
        @(posedge clk_in);
        #1;
    endtask
    // f[0] is the start bit, f[5] the stop bit
    task automatic frame(input logic [0:5] f);
        for (int i = 0; i < 6; i++) step(f[i]);
    endtask
    initial begin
        bus.bit_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_col", 32'(bus.col_index), 0);
        chk("rst_tog", 32'(bus.col_toggle), 0);
        chk("rst_ok", 32'(bus.frame_ok), 0);
        chk("rst_errs", 32'({bus.parity_err, bus.frame_err, bus.range_err}), 0);
        chk("rst_cnt", 32'(bus.err_count), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        step(1'b1);
        chk("busy_start", 32'(bus.busy), 1);
        for (int i = 0; i < 5; i++) step(i == 0 || i == 2 || i == 3);
        chk("f5_col", 32'(bus.col_index), 5);
        chk("f5_tog", 32'(bus.col_toggle), 1);
        chk("f5_ok", 32'(bus.frame_ok), 1);
        chk("f5_cnt", 32'(bus.err_count), 0);
        chk("f5_busy", 32'(bus.busy), 0);
        step(1'b0);
        chk("f5_ok_clr", 32'(bus.frame_ok), 0);
        chk("f5_hold", 32'(bus.col_index), 5);
        frame(6'b101000);
        chk("f2_col", 32'(bus.col_index), 2);
        chk("f2_tog", 32'(bus.col_toggle), 0);
        chk("f2_ok", 32'(bus.frame_ok), 1);
        step(1'b1);
        chk("b2b_ok_clr", 32'(bus.frame_ok), 0);
        chk("b2b_busy", 32'(bus.busy), 1);
        step(1'b0); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
        chk("f0_col", 32'(bus.col_index), 0);
        chk("f0_tog", 32'(bus.col_toggle), 1);
        chk("f0_ok", 32'(bus.frame_ok), 1);
        frame(6'b110100);
        chk("par_err", 32'(bus.parity_err), 1);
        chk("par_ok", 32'(bus.frame_ok), 0);
        chk("par_cnt", 32'(bus.err_count), 1);
        chk("par_col", 32'(bus.col_index), 0);
        chk("par_tog", 32'(bus.col_toggle), 1);
        frame(6'b111100);
        chk("rng_err", 32'(bus.range_err), 1);
        chk("rng_par", 32'(bus.parity_err), 0);
        chk("rng_cnt", 32'(bus.err_count), 2);
        chk("rng_tog", 32'(bus.col_toggle), 1);
        frame(6'b110111);
        chk("stp_err", 32'(bus.frame_err), 1);
        chk("stp_cnt", 32'(bus.err_count), 3);
        chk("stp_busy", 32'(bus.busy), 0);
        step(1'b0);
        chk("stp_clr", 32'(bus.frame_err), 0);
        chk("stp_idle", 32'(bus.busy), 0);
        frame(6'b110101);
        chk("prio_frame", 32'(bus.frame_err), 1);
        chk("prio_par", 32'(bus.parity_err), 0);
        chk("prio_cnt", 32'(bus.err_count), 4);
        step(1'b0);
        step(1'b1); step(1'b1); step(1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_col", 32'(bus.col_index), 0);
        chk("arst_tog", 32'(bus.col_toggle), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_cnt", 32'(bus.err_count), 0);
        @(negedge clk_in);
        reset = 1'b0;
        frame(6'b101000);
        chk("post_col", 32'(bus.col_index), 2);
        chk("post_tog", 32'(bus.col_toggle), 1);
        chk("post_ok", 32'(bus.frame_ok), 1);
        chk("post_cnt", 32'(bus.err_count), 0);
        for (int i = 0; i < 255; i++) frame(6'b111100);
        chk("sat_255", 32'(bus.err_count), 255);
        frame(6'b111100);
        chk("sat_hold", 32'(bus.err_count), 255);
        chk("sat_rng", 32'(bus.range_err), 1);
        chk("sat_col", 32'(bus.col_index), 2);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
